apb_timer_slave: RTL
====================

// Module: apb_timer_slave
// PURPOSE
//  APB3 slave peripheral downstream of the AHB-to-APB bridge: a prescaled down-counter timer with an
//  interrupt, behind a 5-register APB bank. Inserts a parameterised number of wait states (PREADY low)
//  and flags bad addresses with PSLVERR.
//  Serves as the first real peripheral on the APB segment and as the bridge's wait-state test target.
// PARAMETERS
//  ADDR_W       12  PADDR width; word offset decoded from PADDR[ADDR_W-1:2], PADDR[1:0] ignored
//  COUNT_W      32  timer counter / LOAD width (<=32)
//  PRESC_W      16  prescaler width (<=32)
//  WAIT_STATES   0  access-phase cycles with PREADY low before completion (0..15)
// PORTS
//  PCLK     in   1        clock
//  PRESET   in   1        synchronous reset, active-high
//  PSEL     in   1        APB select
//  PENABLE  in   1        APB access phase
//  PWRITE   in   1        1=write, 0=read
//  PADDR    in   ADDR_W   byte address
//  PWDATA   in   32       write data
//  PRDATA   out  32       read data, valid only in the completing cycle, else 0
//  PREADY   out  1        transfer completes this cycle
//  PSLVERR  out  1        error, valid only in the completing cycle, else 0
//  IRQ      out  1        level interrupt = STATUS.PEND & CTRL.IRQ_EN
// BEHAVIOUR
//  Clock/reset: one clock, PCLK; PRESET is synchronous and active-high.
//  Reset: all registers 0, wait counter 0; PREADY=0, PRDATA=0, PSLVERR=0, IRQ=0.
//   A reset mid-transfer aborts it with no register update.
//  Register map (word offset):
//   0x00 CTRL      RW  [0]EN [1]AUTO_RELOAD [2]IRQ_EN; other bits read 0
//   0x04 PRESCALE  RW  [PRESC_W-1:0]
//   0x08 LOAD      RW  [COUNT_W-1:0]; a write also copies the value into COUNT and clears the prescaler
//   0x0C COUNT     RO  current count; writes ignored, no error
//   0x10 STATUS    W1C [0]PEND
//   Any other offset: PSLVERR=1 on completion, PRDATA=0, no state change.
//  APB handshake:
//   - wcnt increments each cycle that PSEL&PENABLE&!PREADY holds, and clears otherwise.
//   - PREADY = PSEL & PENABLE & (wcnt==WAIT_STATES); combinational from registered wcnt.
//   - WAIT_STATES=0 gives a zero-wait access. N gives PREADY low for N access cycles, high on cycle N+1.
//   - Completion cycle = PSEL&PENABLE&PREADY. Writes commit at the PCLK edge ending it.
//   - Reads return the pre-edge register value in PRDATA.
//   - Setup phase (PSEL&!PENABLE) has no side effects.
//  Timer (runs every cycle, independent of APB):
//   - EN=0: prescaler held at 0 and COUNT frozen.
//   - EN 0->1 write: prescaler cleared.
//   - EN=1: psc increments; when psc==PRESCALE, psc<=0 and a tick fires. Tick period = PRESCALE+1 cycles.
//   - Tick with COUNT!=0: COUNT<=COUNT-1.
//   - Tick with COUNT==0 (expiry): PEND<=1.
//     AUTO_RELOAD=1: COUNT<=LOAD. AUTO_RELOAD=0: COUNT stays 0 and EN<=0.
//   - Expiry period = (LOAD+1)*(PRESCALE+1) cycles. No wrap below 0.
//  Simultaneous events:
//   - LOAD write and tick in the same cycle: the write wins (COUNT<=new LOAD).
//   - STATUS W1C and expiry in the same cycle: the set wins (PEND stays 1).
//   - CTRL write clearing EN and expiry in the same cycle: expiry still sets PEND; EN ends at 0.
//   - CTRL write setting EN and expiry auto-clearing EN in the same cycle: the write wins.
// TESTING
//  T1 Assert PRESET for 2 cycles mid-transfer -> PREADY/PRDATA/PSLVERR/IRQ=0; all registers read 0.
//  T2 WAIT_STATES=2, write LOAD=5 -> PREADY low 2 access cycles, high on 3rd; read COUNT -> 5.
//  T3 PRESCALE=1, LOAD=3, CTRL=0x5 -> COUNT 3,2,1,0 every 2 cycles.
//     Expiry at cycle 8 -> PEND=1, IRQ=1, CTRL reads 0x4.
//  T4 AUTO_RELOAD: PRESCALE=0, LOAD=2, CTRL=0x7 -> PEND every 3 cycles; COUNT sequence 2,1,0,2,1,0.
//  T5 STATUS W1C: write 0x1 -> IRQ=0 next cycle. W1C on the expiry cycle -> PEND stays 1.
//  T6 Read/write offset 0x20 -> PSLVERR=1, PRDATA=0, no register changes. Write COUNT -> no effect, PSLVERR=0.

Source files
------------

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB3 slave wrapping a prescaled down-counter timer with a
// level interrupt. Five-word register bank, configurable wait states, and
// PSLVERR on any unmapped word offset.
module apb_timer_slave #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned PRESC_W     = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              IRQ
);

  localparam int unsigned      OFF_W = ADDR_W - 2;
  localparam logic [3:0]       WS    = 4'(WAIT_STATES);

  localparam logic [OFF_W-1:0] OFF_CTRL     = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_PRESCALE = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_LOAD     = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_COUNT    = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_STATUS   = OFF_W'(4);

  // Bus-side state
  logic [3:0]         wcnt_q, wcnt_d;

  // Register bank
  logic               en_q, en_d;
  logic               ar_q, ar_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [COUNT_W-1:0] load_q, load_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pend_q, pend_d;

  // Timer state
  logic [PRESC_W-1:0] psc_q, psc_d;

  // Decode / handshake
  logic [OFF_W-1:0]   off;
  logic               hit_ctrl, hit_presc, hit_load, hit_count, hit_status;
  logic               addr_ok;
  logic               access;
  logic               done;
  logic               wr_ctrl, wr_presc, wr_load, wr_status;
  logic [31:0]        rdata;

  // Timer events
  logic               tick;
  logic               expire;

  // Byte-lane bits of the address carry no meaning for word registers
  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^PADDR[1:0];

  assign off    = PADDR[ADDR_W-1:2];
  assign access = PSEL & PENABLE & ~PRESET;

  // Address decode of the word offset
  always_comb begin
    hit_ctrl   = (off == OFF_CTRL);
    hit_presc  = (off == OFF_PRESCALE);
    hit_load   = (off == OFF_LOAD);
    hit_count  = (off == OFF_COUNT);
    hit_status = (off == OFF_STATUS);
    addr_ok    = hit_ctrl | hit_presc | hit_load | hit_count | hit_status;
  end

  // PREADY is gated by reset so an interrupted transfer can never complete
  assign PREADY = access & (wcnt_q == WS);
  assign done   = PREADY;

  // Write strobes: one per writable register, only on the completing cycle
  always_comb begin
    wr_ctrl   = done & PWRITE & hit_ctrl;
    wr_presc  = done & PWRITE & hit_presc;
    wr_load   = done & PWRITE & hit_load;
    wr_status = done & PWRITE & hit_status;
  end

  // Read mux: pre-edge register contents, zero-extended
  always_comb begin
    rdata = '0;
    if (hit_ctrl)   rdata = {29'd0, ie_q, ar_q, en_q};
    if (hit_presc)  rdata = 32'(presc_q);
    if (hit_load)   rdata = 32'(load_q);
    if (hit_count)  rdata = 32'(count_q);
    if (hit_status) rdata = {31'd0, pend_q};
  end

  assign PRDATA  = (done & ~PWRITE & addr_ok) ? rdata : '0;
  assign PSLVERR = done & ~addr_ok;
  assign IRQ     = ~PRESET & pend_q & ie_q;

  // Wait-state counter: counts stalled access cycles, clears otherwise
  always_comb begin
    wcnt_d = '0;
    if (access && !PREADY) wcnt_d = wcnt_q + 4'd1;
  end

  // Prescaler tick and counter expiry detection
  always_comb begin
    tick   = en_q && (psc_q == presc_q);
    expire = tick && (count_q == '0);
  end

  // Prescaler: held at 0 while disabled (so an EN 0->1 write starts from 0),
  // wraps on each tick, and restarts on a LOAD write
  always_comb begin
    psc_d = psc_q + 1'b1;
    if (!en_q || tick) psc_d = '0;
    if (wr_load)       psc_d = '0;
  end

  // Control register; a CTRL write overrides the one-shot auto-disable
  always_comb begin
    en_d = en_q;
    ar_d = ar_q;
    ie_d = ie_q;
    if (expire && !ar_q) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d = PWDATA[0];
      ar_d = PWDATA[1];
      ie_d = PWDATA[2];
    end
  end

  // PRESCALE and LOAD configuration registers
  always_comb begin
    presc_d = presc_q;
    load_d  = load_q;
    if (wr_presc) presc_d = PWDATA[PRESC_W-1:0];
    if (wr_load)  load_d  = PWDATA[COUNT_W-1:0];
  end

  // Down-counter: decrement on tick, reload or hold at 0 on expiry;
  // a LOAD write in the same cycle takes precedence over the tick
  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else if (ar_q)     count_d = load_q;
      else               count_d = '0;
    end
    if (wr_load) count_d = PWDATA[COUNT_W-1:0];
  end

  // Pending flag: W1C, but a simultaneous expiry keeps it set
  always_comb begin
    pend_d = pend_q;
    if (wr_status && PWDATA[0]) pend_d = 1'b0;
    if (expire)                 pend_d = 1'b1;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wcnt_q  <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      presc_q <= '0;
      load_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      psc_q   <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      presc_q <= presc_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      psc_q   <= psc_d;
    end
  end

endmodule
